// File: rtl/riscv_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : riscv_fetch_queue
// Purpose  : Instruction-fetch front end. It issues word-aligned fetch
//            requests to a variable-latency, in-order instruction memory,
//            buffers up to DEPTH returned instructions, and hands them to
//            decode over a valid/ready handshake. A redirect flushes the
//            buffer and discards the responses still in flight.
// Ports    : clk, reset (async, active low)
//            imem_req_valid/ready/addr  - fetch request channel
//            imem_rsp_valid/data        - in-order response channel
//            redirect_valid/pc          - flush and restart fetch
//            out_valid/ready/instr/pc   - decode-side handshake
//            busy                       - a request is outstanding
// Options  : FETCH_BYPASS_EN - when defined, a response arriving at an empty
//            queue is presented to decode in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_fetch_queue #(
  parameter int              XLEN            = 32,
  parameter int              DEPTH           = 4,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int              MAX_OUTSTANDING = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            busy
);

  localparam int            AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW        = AW + 1;
  localparam logic [CW:0]   DEPTH_SUM = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] MAX_OUT   = CW'(MAX_OUTSTANDING);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] q_instr [DEPTH];
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [XLEN-1:0] tag_pc  [DEPTH];
  logic [AW-1:0]   q_head, q_tail, tag_head, tag_tail;
  logic [CW-1:0]   count, outstanding, drop_cnt;
  logic [CW-1:0]   outstanding_next, drop_next;
  logic [CW:0]     reserved;
  logic            accept, rsp_live, push, pop, bypass, q_nonempty;
  logic            unused_redirect_bits;

  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign q_nonempty = (count != '0);
  // Queue slots already holding data plus slots promised to in-flight
  // requests; issuing only below DEPTH means a response always has room.
  assign reserved   = {1'b0, count} + {1'b0, outstanding};

  assign imem_req_valid = reset && (state == FETCH) &&
                          (reserved < DEPTH_SUM) && (outstanding < MAX_OUT);
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign rsp_live       = imem_rsp_valid && (drop_cnt == '0);
  assign busy           = (outstanding != '0);

`ifdef FETCH_BYPASS_EN
  assign bypass    = reset && !q_nonempty && rsp_live;
  assign out_valid = q_nonempty || bypass;
  assign out_instr = q_nonempty ? q_instr[q_head] : (bypass ? imem_rsp_data : '0);
  assign out_pc    = q_nonempty ? q_pc[q_head] : (bypass ? tag_pc[tag_head] : '0);
`else
  assign bypass    = 1'b0;
  assign out_valid = q_nonempty;
  assign out_instr = q_nonempty ? q_instr[q_head] : '0;
  assign out_pc    = q_nonempty ? q_pc[q_head] : '0;
`endif

  assign pop  = q_nonempty && out_ready;
  // A bypassed response that decode takes immediately never occupies a slot.
  assign push = rsp_live && !(bypass && out_ready);

  assign outstanding_next = outstanding + CW'(accept) - CW'(imem_rsp_valid);

  // On a redirect every response still owed after this cycle is stale,
  // including one for a request accepted in the redirect cycle itself.
  // While draining, outstanding and drop_cnt track each other, so the same
  // expression also keeps drop_cnt across a second redirect.
  always_comb begin
    drop_next = drop_cnt;
    if (redirect_valid) begin
      drop_next = outstanding_next;
    end else if (imem_rsp_valid && (drop_cnt != '0)) begin
      drop_next = drop_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:   if (drop_next != '0) state_next = DRAIN;
      DRAIN:   if (drop_next == '0) state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      count       <= '0;
      q_head      <= '0;
      q_tail      <= '0;
      tag_head    <= '0;
      tag_tail    <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_next;
      drop_cnt    <= drop_next;
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        count    <= '0;
        q_head   <= '0;
        q_tail   <= '0;
        tag_head <= '0;
        tag_tail <= '0;
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + XLEN'(4);
          tag_tail <= tag_tail + AW'(1);
        end
        if (rsp_live) tag_head <= tag_head + AW'(1);
        if (push)     q_tail   <= q_tail + AW'(1);
        if (pop)      q_head   <= q_head + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage needs no reset: outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push && !redirect_valid) begin
      q_instr[q_tail] <= imem_rsp_data;
      q_pc[q_tail]    <= tag_pc[tag_head];
    end
    if (accept && !redirect_valid) begin
      tag_pc[tag_tail] <= fetch_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_fetch_queue
// Purpose  : Randomised bench for riscv_fetch_queue with an in-order,
//            variable-latency instruction memory and a queue-based reference
//            model of the fetch stream, redirects and stale-response drops.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          MAXO     = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_pc;
  logic        busy;

  riscv_fetch_queue #(
    .XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; bit stale; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  req_t        pend[$];   // requests the memory owes a response for, in order
  ent_t        mq[$];     // instructions decode should see, in order
  logic [31:0] next_fetch;
  int          cyc, last_due;
  int          tests_run, tests_failed;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
    check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_out_instr"}, out_instr, 32'd0);
    check({tag, "_out_pc"},    out_pc, 32'd0);
    check({tag, "_busy"},      {31'b0, busy}, 32'd0);
  endtask

  // One clock cycle: entered and left at a falling edge.
  task automatic run_cycle(input int rdy_pct, input int ord_pct, input int redir_pct,
                           input int lat_min, input int lat_max, output bit popped);
    bit          have_rsp, exp_rv, exp_ov, exp_byp;
    logic [31:0] exp_pc, exp_in, rp;
    req_t        r;
    int          due;
    cyc++;
    have_rsp       = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_rsp_valid = have_rsp;
    imem_rsp_data  = have_rsp ? (pend[0].stale ? 32'hDEAD_BEEF : instr_of(pend[0].addr)) : 32'h0;
    imem_req_ready = ($urandom_range(0, 99) < rdy_pct);
    out_ready      = ($urandom_range(0, 99) < ord_pct);
    redirect_valid = ($urandom_range(0, 99) < redir_pct);
    if ($urandom_range(0, 9) == 0) rp = 32'hFFFF_FFF0 | ($urandom & 32'hF);
    else                           rp = $urandom & 32'h0000_0FFF;
    redirect_pc = rp;
    #1;
    exp_rv = !((pend.size() > 0) && pend[0].stale) &&
             (mq.size() + pend.size() < DEPTH) && (pend.size() < MAXO);
`ifdef FETCH_BYPASS_EN
    exp_byp = (mq.size() == 0) && have_rsp && !pend[0].stale;
`else
    exp_byp = 1'b0;
`endif
    exp_ov = (mq.size() > 0) || exp_byp;
    check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
    if (exp_rv) check("req_addr", imem_req_addr, next_fetch);
    check("busy", {31'b0, busy}, {31'b0, pend.size() != 0});
    check("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
    if (exp_ov) begin
      exp_pc = (mq.size() > 0) ? mq[0].pc    : pend[0].addr;
      exp_in = (mq.size() > 0) ? mq[0].instr : instr_of(pend[0].addr);
      check("out_pc", out_pc, exp_pc);
      check("out_instr", out_instr, exp_in);
    end
    // Advance the model across the coming rising edge.
    popped = exp_ov && out_ready;
    if (popped && mq.size() > 0) void'(mq.pop_front());
    if (have_rsp) begin
      r = pend.pop_front();
      if (!r.stale && !(exp_byp && out_ready)) mq.push_back('{r.addr, instr_of(r.addr)});
    end
    if (exp_rv && imem_req_ready) begin
      due = cyc + $urandom_range(lat_min, lat_max);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{next_fetch, 1'b0, due});
      next_fetch = next_fetch + 32'd4;
    end
    if (redirect_valid) begin
      mq.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      next_fetch = {rp[31:2], 2'b00};
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_phase(input int rdy_pct, input int ord_pct, input int redir_pct,
                           input int lat_min, input int lat_max, input int n,
                           input int win_start, output int pops);
    bit p;
    pops = 0;
    for (int i = 0; i < n; i++) begin
      run_cycle(rdy_pct, ord_pct, redir_pct, lat_min, lat_max, p);
      if (p && i >= win_start) pops++;
    end
  endtask

  task automatic reset_mid_stream();
    reset          = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    #1;
    check_reset_outputs("midrst");
    pend.delete();
    mq.delete();
    next_fetch = RESET_PC;
    last_due   = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int pops;
    tests_run      = 0;
    tests_failed   = 0;
    cyc            = 0;
    last_due       = 0;
    next_fetch     = RESET_PC;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    #1 reset = 1'b0;
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Streaming with 1-cycle memory: one instruction per cycle once filled.
    run_phase(100, 100, 0, 1, 1, 30, 10, pops);
    check("throughput", pops, 32'd20);
    // Decode stalled: the queue fills, then issue stops.
    run_phase(100, 0, 0, 1, 1, 15, 0, pops);
    // Decode resumes: buffered entries drain in order, issue continues.
    run_phase(100, 100, 0, 1, 1, 12, 0, pops);
    // Random traffic with occasional redirects.
    run_phase(70, 60, 4, 1, 5, 1500, 0, pops);
    // Redirect-heavy traffic: frequent drains and redirects while draining.
    run_phase(80, 50, 15, 2, 5, 800, 0, pops);
    reset_mid_stream();
    run_phase(70, 60, 4, 1, 5, 500, 0, pops);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
